// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline controller: PC mux selects, operand
// forwarding selects and interrupt FSM states.
package pipe_pkg;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_VEC = 2'b10,
    PC_EPC = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    FW_RF  = 2'b00,
    FW_WB  = 2'b01,
    FW_MEM = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_HANDLER = 2'b10
  } irq_state_e;

  // Wide enough for LOAD_LAT-1 with LOAD_LAT up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-facing signal bundle of the pipeline controller. The pipeline side
// (master) supplies stage fields; the controller (slave) returns hold/flush/select.
interface pipe_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use1;
  logic              id_use2;
  logic              id_mret;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic              ex_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic              mem_regwrite;
  logic              wb_regwrite;
  logic              br_taken;
  logic              interrupt;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic [1:0]        pc_sel;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic [XLEN-1:0]   epc;
  logic              irq_active;

  modport master (
    output id_rs1, id_rs2, id_use1, id_use2, id_mret, ex_valid, ex_pc,
           ex_rs1, ex_rs2, ex_rd, ex_memread, ex_regwrite, mem_rd, wb_rd,
           mem_regwrite, wb_regwrite, br_taken, interrupt,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, pc_sel, forward_a, forward_b, epc, irq_active
  );

  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2, id_mret, ex_valid, ex_pc,
           ex_rs1, ex_rs2, ex_rd, ex_memread, ex_regwrite, mem_rd, wb_rd,
           mem_regwrite, wb_regwrite, br_taken, interrupt,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
           exmem_flush, pc_sel, forward_a, forward_b, epc, irq_active
  );
endinterface

// File: rtl/pipe_ctrl_fwd_sel.sv
// Forwarding select for one EX operand; the younger MEM result beats WB,
// and x0 is never forwarded.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  // Priority compare of MEM then WB destination against the operand.
  always_comb begin
    sel = FW_RF;
    if (mem_regwrite && (mem_rd != {REG_AW{1'b0}}) && (mem_rd == ex_rs)) begin
      sel = FW_MEM;
    end else if (wb_regwrite && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == ex_rs)) begin
      sel = FW_WB;
    end else begin
      sel = FW_RF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: forwarding, load-use stalls, branch flushes and a precise
// interrupt entry/return FSM. Hold/flush/select outputs react in the same cycle.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter int              LOAD_LAT = 1,
  parameter logic [XLEN-1:0] IRQ_VEC  = 32'h0000_0100
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_lat
    $error("pipe_ctrl: LOAD_LAT must be in 1..7");
  end
  if (IRQ_VEC[1:0] != 2'b00) begin : g_bad_vec
    $error("pipe_ctrl: IRQ_VEC must be word aligned");
  end

  irq_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pending_r;
  logic             irq_prev_r;
  logic             irq_active_r;
  logic [XLEN-1:0]  epc_r;

  logic       hz_s, stall_s, rise_s, pend_s, take_s, mret_s;
  logic [1:0] fa_s, fb_s, pc_sel_s;
  logic       pc_write_s, ifid_write_s, idex_bubble_s;
  logic       ifid_flush_s, idex_flush_s, exmem_flush_s;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs(bus.ex_rs1), .mem_rd(bus.mem_rd), .mem_regwrite(bus.mem_regwrite),
    .wb_rd(bus.wb_rd), .wb_regwrite(bus.wb_regwrite), .sel(fa_s)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs(bus.ex_rs2), .mem_rd(bus.mem_rd), .mem_regwrite(bus.mem_regwrite),
    .wb_rd(bus.wb_rd), .wb_regwrite(bus.wb_regwrite), .sel(fb_s)
  );

  assign hz_s = bus.ex_valid && bus.ex_memread && bus.ex_regwrite &&
                (bus.ex_rd != {REG_AW{1'b0}}) &&
                ((bus.id_use1 && (bus.ex_rd == bus.id_rs1)) ||
                 (bus.id_use2 && (bus.ex_rd == bus.id_rs2)));
  assign stall_s = hz_s || (cnt_r != {CNT_W{1'b0}});
  assign rise_s  = bus.interrupt && !irq_prev_r;
  assign pend_s  = pending_r || rise_s;
  // The EX instruction is killed at entry and re-executed from epc on return.
  assign take_s  = (state_r == ST_PENDING) && bus.ex_valid && !bus.br_taken && !stall_s;
  assign mret_s  = (state_r == ST_HANDLER) && bus.id_mret && !bus.br_taken && !stall_s;

  // Priority decode of hold/flush/PC select: branch, interrupt entry, stall, mret.
  always_comb begin
    pc_sel_s      = PC_INC;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    idex_bubble_s = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    if (!rst) begin
      pc_sel_s = PC_INC;
    end else if (bus.br_taken) begin
      pc_sel_s      = PC_BR;
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
      exmem_flush_s = 1'b1;
    end else if (take_s) begin
      pc_sel_s      = PC_VEC;
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
      exmem_flush_s = 1'b1;
    end else if (stall_s) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_bubble_s = 1'b1;
    end else if (mret_s) begin
      pc_sel_s     = PC_EPC;
      ifid_flush_s = 1'b1;
    end else begin
      pc_sel_s = PC_INC;
    end
  end

  assign bus.pc_sel      = pc_sel_s;
  assign bus.pc_write    = pc_write_s;
  assign bus.ifid_write  = ifid_write_s;
  assign bus.idex_bubble = idex_bubble_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.idex_flush  = idex_flush_s;
  assign bus.exmem_flush = exmem_flush_s;
  assign bus.forward_a   = rst ? fa_s : FW_RF;
  assign bus.forward_b   = rst ? fb_s : FW_RF;
  assign bus.epc         = epc_r;
  assign bus.irq_active  = irq_active_r;

  // Stall counter, interrupt edge/pending tracking and the interrupt FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      pending_r    <= 1'b0;
      irq_prev_r   <= 1'b0;
      irq_active_r <= 1'b0;
      epc_r        <= {XLEN{1'b0}};
    end else begin
      irq_prev_r <= bus.interrupt;

      if (bus.br_taken) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (hz_s && (cnt_r == {CNT_W{1'b0}})) begin
        cnt_r <= CNT_W'(LOAD_LAT - 1);
      end else if (cnt_r != {CNT_W{1'b0}}) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end

      if (rise_s) begin
        pending_r <= 1'b1;
      end else if (take_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end

      case (state_r)
        ST_IDLE: begin
          state_r <= pend_s ? ST_PENDING : ST_IDLE;
        end
        ST_PENDING: begin
          if (take_s) begin
            state_r      <= ST_HANDLER;
            irq_active_r <= 1'b1;
            epc_r        <= bus.ex_pc;
          end else begin
            state_r <= ST_PENDING;
          end
        end
        ST_HANDLER: begin
          if (mret_s) begin
            state_r      <= pend_s ? ST_PENDING : ST_IDLE;
            irq_active_r <= 1'b0;
          end else begin
            state_r <= ST_HANDLER;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          irq_active_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for forwarding/hazard/branch
// decode plus hand sequences for stall length, interrupt entry/return and reset.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  pipe_ctrl_if #(.XLEN(32), .REG_AW(5)) bus1 ();
  pipe_ctrl_if #(.XLEN(32), .REG_AW(5)) bus3 ();

  pipe_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_LAT(1), .IRQ_VEC(32'h0000_0100)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  pipe_ctrl #(.XLEN(32), .REG_AW(5), .LOAD_LAT(3), .IRQ_VEC(32'h0000_0100)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ex_rs1, ex_rs2, mem_rd, wb_rd, id_rs1, id_rs2, ex_rd;
    logic        mem_rw, wb_rw, use1, use2, ex_valid, ld, br;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {forward_a, forward_b, pc_write, ifid_write, idex_bubble, pc_sel, ifid/idex/exmem flush}
  function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic pw, input logic bub,
                                     input logic [1:0] ps, input logic [2:0] fl);
    return {fa, fb, pw, pw, bub, ps, fl};
  endfunction

  function automatic vec_t mkv(input logic [4:0] ex_rs1, input logic [4:0] ex_rs2,
                               input logic [4:0] mem_rd, input logic mem_rw,
                               input logic [4:0] wb_rd, input logic wb_rw,
                               input logic [4:0] id_rs1, input logic [4:0] id_rs2,
                               input logic use1, input logic use2, input logic ex_valid,
                               input logic ld, input logic [4:0] ex_rd, input logic br,
                               input logic [11:0] exp);
    vec_t v;
    v.ex_rs1 = ex_rs1; v.ex_rs2 = ex_rs2; v.mem_rd = mem_rd; v.mem_rw = mem_rw;
    v.wb_rd = wb_rd; v.wb_rw = wb_rw; v.id_rs1 = id_rs1; v.id_rs2 = id_rs2;
    v.use1 = use1; v.use2 = use2; v.ex_valid = ex_valid; v.ld = ld;
    v.ex_rd = ex_rd; v.br = br; v.exp = exp;
    return v;
  endfunction

  function automatic logic [11:0] out1();
    return {bus1.forward_a, bus1.forward_b, bus1.pc_write, bus1.ifid_write, bus1.idex_bubble,
            bus1.pc_sel, bus1.ifid_flush, bus1.idex_flush, bus1.exmem_flush};
  endfunction

  function automatic logic [11:0] out3();
    return {bus3.forward_a, bus3.forward_b, bus3.pc_write, bus3.ifid_write, bus3.idex_bubble,
            bus3.pc_sel, bus3.ifid_flush, bus3.idex_flush, bus3.exmem_flush};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle1();
    bus1.id_rs1 = 5'd0; bus1.id_rs2 = 5'd0; bus1.id_use1 = 1'b0; bus1.id_use2 = 1'b0;
    bus1.id_mret = 1'b0; bus1.ex_valid = 1'b0; bus1.ex_pc = 32'h0;
    bus1.ex_rs1 = 5'd0; bus1.ex_rs2 = 5'd0; bus1.ex_rd = 5'd0;
    bus1.ex_memread = 1'b0; bus1.ex_regwrite = 1'b0; bus1.mem_rd = 5'd0; bus1.wb_rd = 5'd0;
    bus1.mem_regwrite = 1'b0; bus1.wb_regwrite = 1'b0; bus1.br_taken = 1'b0;
    bus1.interrupt = 1'b0;
  endtask

  task automatic idle3();
    bus3.id_rs1 = 5'd0; bus3.id_rs2 = 5'd0; bus3.id_use1 = 1'b0; bus3.id_use2 = 1'b0;
    bus3.id_mret = 1'b0; bus3.ex_valid = 1'b0; bus3.ex_pc = 32'h0;
    bus3.ex_rs1 = 5'd0; bus3.ex_rs2 = 5'd0; bus3.ex_rd = 5'd0;
    bus3.ex_memread = 1'b0; bus3.ex_regwrite = 1'b0; bus3.mem_rd = 5'd0; bus3.wb_rd = 5'd0;
    bus3.mem_regwrite = 1'b0; bus3.wb_regwrite = 1'b0; bus3.br_taken = 1'b0;
    bus3.interrupt = 1'b0;
  endtask

  // lw x3 in EX while ID reads x3 as rs1
  task automatic load_use3();
    bus3.ex_valid = 1'b1; bus3.ex_memread = 1'b1; bus3.ex_regwrite = 1'b1;
    bus3.ex_rd = 5'd3; bus3.id_rs1 = 5'd3; bus3.id_use1 = 1'b1;
  endtask

  localparam logic [11:0] RST_O = 12'h0C0;
  localparam logic [11:0] STALL_O = 12'h020;
  localparam logic [11:0] BR_O = 12'h0CF;
  localparam logic [11:0] VEC_O = 12'h0D7;
  localparam logic [11:0] EPC_O = 12'h0DC;

  initial begin
    int held;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    idle1();
    idle3();

    // Reset state with inputs that would otherwise forward and branch
    bus1.ex_rs1 = 5'd5; bus1.mem_rd = 5'd5; bus1.mem_regwrite = 1'b1; bus1.br_taken = 1'b1;
    load_use3();
    #2;
    chk("rst_out1", out1(), RST_O);
    chk("rst_out3", out3(), RST_O);
    chk("rst_epc", bus1.epc, 32'h0);
    chk("rst_irq", bus1.irq_active, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle1();
    idle3();

    vecs.push_back(mkv(5'd5, 5'd6, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, mk(2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000)));
    vecs.push_back(mkv(5'd0, 5'd6, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, RST_O));
    vecs.push_back(mkv(5'd5, 5'd5, 5'd5, 1'b0, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, mk(2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000)));
    vecs.push_back(mkv(5'd5, 5'd7, 5'd7, 1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, mk(2'b01, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000)));
    vecs.push_back(mkv(5'd9, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, mk(2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000)));
    vecs.push_back(mkv(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, STALL_O));
    vecs.push_back(mkv(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, RST_O));
    vecs.push_back(mkv(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, STALL_O));
    vecs.push_back(mkv(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, RST_O));
    vecs.push_back(mkv(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, RST_O));
    vecs.push_back(mkv(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, BR_O));
    vecs.push_back(mkv(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, RST_O));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus1.ex_rs1 = vecs[i].ex_rs1; bus1.ex_rs2 = vecs[i].ex_rs2;
      bus1.mem_rd = vecs[i].mem_rd; bus1.mem_regwrite = vecs[i].mem_rw;
      bus1.wb_rd = vecs[i].wb_rd; bus1.wb_regwrite = vecs[i].wb_rw;
      bus1.id_rs1 = vecs[i].id_rs1; bus1.id_rs2 = vecs[i].id_rs2;
      bus1.id_use1 = vecs[i].use1; bus1.id_use2 = vecs[i].use2;
      bus1.ex_valid = vecs[i].ex_valid; bus1.ex_memread = vecs[i].ld;
      bus1.ex_regwrite = vecs[i].ld; bus1.ex_rd = vecs[i].ex_rd; bus1.br_taken = vecs[i].br;
      #2;
      chk($sformatf("vec%0d", i), out1(), vecs[i].exp);
    end

    // Held-cycle count per load-use hazard; EX becomes a bubble after the first cycle
    @(negedge clk);
    idle1();
    bus1.ex_valid = 1'b1; bus1.ex_memread = 1'b1; bus1.ex_regwrite = 1'b1;
    bus1.ex_rd = 5'd3; bus1.id_rs1 = 5'd3; bus1.id_use1 = 1'b1;
    held = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (!bus1.pc_write && bus1.idex_bubble) held++;
      @(negedge clk);
      bus1.ex_valid = 1'b0;
    end
    chk("lat1_held", held, 1);
    idle1();

    load_use3();
    held = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (!bus3.pc_write && bus3.idex_bubble) held++;
      @(negedge clk);
      bus3.ex_valid = 1'b0;
    end
    chk("lat3_held", held, 3);

    // Branch during a counter-driven stall
    idle3();
    load_use3();
    #2;
    chk("bs_stall", out3(), STALL_O);
    @(negedge clk);
    bus3.ex_valid = 1'b0;
    bus3.br_taken = 1'b1;
    #2;
    chk("bs_branch", out3(), BR_O);
    @(negedge clk);
    bus3.br_taken = 1'b0;
    #2;
    chk("bs_cnt_clear", out3(), RST_O);

    // Reset while the counter holds 2
    @(negedge clk);
    load_use3();
    @(negedge clk);
    bus3.ex_valid = 1'b0;
    #2;
    chk("rs_stall", out3(), STALL_O);
    bus3.ex_rs1 = 5'd3; bus3.mem_rd = 5'd3; bus3.mem_regwrite = 1'b1;
    rst = 1'b0;
    #1;
    chk("rs_mid_stall", out3(), RST_O);
    @(negedge clk);
    rst = 1'b1;
    idle3();
    #2;
    chk("rs_cleared", out3(), RST_O);

    // Interrupt entry, nested request, return and re-entry
    @(negedge clk);
    idle1();
    bus1.interrupt = 1'b1; bus1.ex_valid = 1'b1; bus1.ex_pc = 32'h40;
    #2;
    chk("irq_edge_cycle", out1(), RST_O);
    @(negedge clk);
    #2;
    chk("irq_take", out1(), VEC_O);
    chk("irq_act_pre", bus1.irq_active, 1'b0);
    @(negedge clk);
    bus1.ex_pc = 32'h44;
    #2;
    chk("irq_epc", bus1.epc, 32'h40);
    chk("irq_active", bus1.irq_active, 1'b1);
    chk("irq_hdl_out", out1(), RST_O);
    @(negedge clk);
    bus1.interrupt = 1'b0; bus1.ex_pc = 32'h80;
    @(negedge clk);
    bus1.interrupt = 1'b1;
    #2;
    chk("nest_no_entry", out1(), RST_O);
    @(negedge clk);
    #2;
    chk("nest_hdl", bus1.irq_active, 1'b1);
    chk("nest_epc", bus1.epc, 32'h40);
    @(negedge clk);
    bus1.id_mret = 1'b1;
    #2;
    chk("mret", out1(), EPC_O);
    @(negedge clk);
    bus1.id_mret = 1'b0; bus1.ex_pc = 32'h90;
    #2;
    chk("mret_drop", bus1.irq_active, 1'b0);
    chk("reentry_take", out1(), VEC_O);
    @(negedge clk);
    #2;
    chk("reentry_epc", bus1.epc, 32'h90);
    chk("reentry_act", bus1.irq_active, 1'b1);

    // Branch beats a coincident mret
    @(negedge clk);
    bus1.id_mret = 1'b1; bus1.br_taken = 1'b1;
    #2;
    chk("mret_vs_br", out1(), BR_O);
    @(negedge clk);
    bus1.id_mret = 1'b0; bus1.br_taken = 1'b0;
    #2;
    chk("br_keeps_hdl", bus1.irq_active, 1'b1);

    // Reset in the handler
    @(negedge clk);
    bus1.id_mret = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rh_out", out1(), RST_O);
    chk("rh_epc", bus1.epc, 32'h0);
    chk("rh_irq", bus1.irq_active, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle1();
    #2;
    chk("rh_after", out1(), RST_O);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control for the 5-stage RISC-V core, replacing the separate hazard-detection and forwarding units.
- Generates forwarding selects, load-use stalls for configurable data-memory latency, and branch flushes.
- Adds a precise interrupt entry/return FSM driven by the core's `interrupt` pin.
- Sits beside the stage registers and drives their write-enable/flush inputs and the PC mux.

Parameters:
XLEN, 32, datapath/PC width
REG_AW, 5, register address width
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7)
IRQ_VEC, 32'h0000_0100, interrupt handler address

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
id_rs1, id_rs2  in  REG_AW  ID source registers
id_use1, id_use2  in  1  ID instruction reads rs1/rs2
id_mret  in  1  ID holds MRET
ex_valid  in  1  EX holds a real instruction (not a bubble)
ex_pc  in  XLEN  EX instruction PC
ex_rs1, ex_rs2, ex_rd  in  REG_AW  EX register fields
ex_memread, ex_regwrite  in  1  EX control
mem_rd, wb_rd  in  REG_AW  destination registers in MEM/WB
mem_regwrite, wb_regwrite  in  1  write enables in MEM/WB
br_taken  in  1  branch resolved taken in MEM
interrupt  in  1  external interrupt request, level
pc_write, ifid_write  out  1  stage hold (0 = hold)
idex_bubble  out  1  zero ID/EX control
ifid_flush, idex_flush, exmem_flush  out  1  kill stage contents
pc_sel  out  2  00 pc+4, 01 branch target, 10 IRQ_VEC, 11 epc
forward_a, forward_b  out  2  00 regfile, 10 MEM, 01 WB
epc  out  XLEN  saved return PC
irq_active  out  1  handler running

Behaviour:
- **Reset (rst=0):**
  - Outputs: pc_write=ifid_write=1; all flush/bubble outputs 0; pc_sel=00; forward_*=00; epc=0; irq_active=0.
  - State: FSM=IDLE, stall counter=0, pending=0.
- **Forwarding (combinational):** forward_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1; else 01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1; else 00. forward_b is the same using ex_rs2. MEM has priority over WB.
- **Load-use hazard:** hz = ex_valid && ex_memread && ex_regwrite && ex_rd!=0 && ((id_use1 && ex_rd==id_rs1) || (id_use2 && ex_rd==id_rs2)).
  - On hz with counter=0: load counter with LOAD_LAT-1.
  - While hz or counter!=0: pc_write=0, ifid_write=0, idex_bubble=1.
  - Counter decrements each cycle to 0. The total number of held cycles is exactly LOAD_LAT.
- **Branch (highest priority):** br_taken forces pc_sel=01 and ifid_flush=idex_flush=exmem_flush=1, with pc_write=1 and ifid_write=1. The stall counter clears in the same cycle.
- **Interrupt FSM, states IDLE/PENDING/HANDLER:**
  - pending is set on a rising edge of `interrupt` (registered previous value). It is also set while in HANDLER; nested requests are deferred, not lost.
  - IDLE→PENDING when pending=1.
  - PENDING: take the interrupt in the first cycle with ex_valid && !br_taken && no stall. In that cycle:
    - epc<=ex_pc (EX instruction is killed and re-executed on return);
    - pc_sel=10; all three flushes=1;
    - pending cleared; next state HANDLER, irq_active=1.
  - HANDLER: id_mret with no stall and no br_taken → pc_sel=11, ifid_flush=1, next state IDLE (or PENDING if pending), irq_active drops next cycle.
  - If br_taken coincides with id_mret, the branch wins and the mret is flushed.
- **Reset mid-operation:** rst asserted at any time returns everything to reset values asynchronously. A stall or handler in progress is abandoned.
- epc holds its value except at interrupt entry.

Decomposition:
- Shared package `pipe_pkg` holds:
  - pc_sel encodings (PC_INC, PC_BR, PC_VEC, PC_EPC);
  - forwarding encodings (FW_RF, FW_MEM, FW_WB);
  - FSM state encodings.
- One sub-module, `fwd_sel`: combinational forwarding for one operand, instantiated twice.

Test Plan:
- add x5 in MEM, add x5 in WB, sub using rs1=x5 in EX → forward_a=10. Same case with rd=x0 → forward_a=00.
- LOAD_LAT=1, lw x3 in EX, ID uses x3 → exactly 1 cycle with pc_write=0 and idex_bubble=1. LOAD_LAT=3 → exactly 3 cycles.
- Load-use stall active and br_taken=1 in the same cycle → stall dropped, pc_sel=01, three flushes=1, counter=0 next cycle.
- interrupt rises, ex_pc=0x40 valid, no hazard → next cycle pc_sel=10, flushes=1, then epc=0x40, irq_active=1. Later id_mret → pc_sel=11, irq_active=0.
- Second interrupt edge during HANDLER → no entry until mret; after mret the FSM re-enters PENDING and takes the interrupt with the new ex_pc.
- rst pulled low mid-stall (counter=2) and mid-HANDLER → all outputs return to reset values immediately.
